// File: rtl/keccak_sel_pkg.sv
// Shared types, defaults and helpers for the Keccak word selector.
// Optional byte-swap build: define KECCAK_SEL_BYTESWAP_EN.
package keccak_sel_pkg;

    localparam int unsigned WIDE_W_DEF = 512;
    localparam int unsigned WORD_W_DEF = 32;
    localparam int unsigned SWAP_MAX_W = 256;

    typedef enum logic [1:0] {
        StIdle,
        StSingle,
        StStream
    } sel_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

    // Reverses the low `width` bits byte-wise; bits above `width` come back zero.
    function automatic logic [SWAP_MAX_W-1:0] byteswap(input logic [SWAP_MAX_W-1:0] w,
                                                      input int unsigned width);
        logic [SWAP_MAX_W-1:0] r;
        int nb;
        r  = '0;
        nb = int'(width / 8);
        for (int i = 0; i < int'(SWAP_MAX_W / 8); i++) begin
            if (i < nb) begin
                r[i*8 +: 8] = w[(nb-1-i)*8 +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/keccak_word_mux.sv
// Combinational word select: returns word idx of a wide buffer (word k = bits k*WORD_W+:WORD_W).
module keccak_word_mux #(
    parameter int unsigned WIDE_W = 512,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned IDX_W  = 4
) (
    input  logic [WIDE_W-1:0] i_buf,
    input  logic [IDX_W-1:0]  i_idx,
    output logic [WORD_W-1:0] o_word
);

    localparam int unsigned NWORDS = WIDE_W / WORD_W;

    logic [WORD_W-1:0] w_words [NWORDS];

    for (genvar k = 0; k < int'(NWORDS); k++) begin : g_split
        assign w_words[k] = i_buf[k*WORD_W +: WORD_W];
    end

    assign o_word = w_words[i_idx];

endmodule

// File: rtl/keccak_word_sel.sv
// Registered wide-to-word selector: captures a Keccak slice, then returns single or streamed words.
// Optional per-read byte reversal of emitted words: define KECCAK_SEL_BYTESWAP_EN.
module keccak_word_sel
    import keccak_sel_pkg::*;
#(
    parameter int unsigned WIDE_W = WIDE_W_DEF,
    parameter int unsigned WORD_W = WORD_W_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
`ifdef KECCAK_SEL_BYTESWAP_EN
    input  logic                                 i_swap_en,
`endif
    input  logic                                 i_load,
    input  logic [WIDE_W-1:0]                    i_in_wide,
    input  logic                                 i_rd_req,
    input  logic                                 i_rd_mode,
    input  logic [clog2(WIDE_W / WORD_W)-1:0]    i_rd_idx,
    input  logic                                 i_abort,
    output logic [WORD_W-1:0]                    o_out_word,
    output logic                                 o_out_valid,
    input  logic                                 i_out_ready,
    output logic                                 o_out_last,
    output logic                                 o_busy
);

    localparam int unsigned NWORDS = WIDE_W / WORD_W;
    localparam int unsigned IDX_W  = clog2(NWORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    if (NWORDS < 2 || (NWORDS & (NWORDS - 1)) != 0 || (WIDE_W % WORD_W) != 0) begin : g_bad_cfg
        $error("keccak_word_sel: WIDE_W/WORD_W must be a power of two >= 2");
    end

    sel_state_e        r_state, w_state_nxt;
    logic [WIDE_W-1:0] r_buf, w_buf_nxt;
    logic [WORD_W-1:0] r_out_word, w_word_nxt;
    logic              r_out_valid, w_valid_nxt;
    logic              r_out_last, w_last_nxt;
    logic [IDX_W-1:0]  r_cur_idx, w_idx_nxt;

    logic [IDX_W-1:0]  w_cur_inc;
    logic [IDX_W-1:0]  w_mux_idx;
    logic [WORD_W-1:0] w_mux_word;
    logic [WORD_W-1:0] w_sel_word;
    logic              w_hs;

    assign w_cur_inc = r_cur_idx + IDX_W'(1);
    // One mux serves both the request index (IDLE) and the stream look-ahead (busy).
    assign w_mux_idx = (r_state == StIdle) ? i_rd_idx : w_cur_inc;
    assign w_hs      = r_out_valid & i_out_ready;

    keccak_word_mux #(
        .WIDE_W (WIDE_W),
        .WORD_W (WORD_W),
        .IDX_W  (IDX_W)
    ) u_mux (
        .i_buf  (r_buf),
        .i_idx  (w_mux_idx),
        .o_word (w_mux_word)
    );

`ifdef KECCAK_SEL_BYTESWAP_EN
    if ((WORD_W % 8) != 0 || WORD_W > SWAP_MAX_W) begin : g_bad_swap_cfg
        $error("keccak_word_sel: byte swap needs WORD_W multiple of 8 and <= SWAP_MAX_W");
    end

    logic                  r_swap;
    logic                  w_swap_sel;
    logic [SWAP_MAX_W-1:0] w_swapped;

    // swap_en is sampled with rd_req and held for the remainder of the read.
    assign w_swap_sel = (r_state == StIdle) ? i_swap_en : r_swap;
    assign w_swapped  = byteswap(SWAP_MAX_W'(w_mux_word), WORD_W);
    assign w_sel_word = w_swap_sel ? w_swapped[WORD_W-1:0] : w_mux_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_swap <= 1'b0;
        end else if (r_state == StIdle && !i_load && i_rd_req) begin
            r_swap <= i_swap_en;
        end
    end
`else
    assign w_sel_word = w_mux_word;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_word_nxt  = r_out_word;
        w_valid_nxt = r_out_valid;
        w_last_nxt  = r_out_last;
        w_idx_nxt   = r_cur_idx;
        unique case (r_state)
            StIdle: begin
                if (i_load) begin
                    w_buf_nxt = i_in_wide;
                end else if (i_rd_req) begin
                    w_word_nxt  = w_sel_word;
                    w_valid_nxt = 1'b1;
                    if (i_rd_mode) begin
                        w_idx_nxt   = i_rd_idx;
                        w_last_nxt  = (i_rd_idx == LAST_IDX);
                        w_state_nxt = StStream;
                    end else begin
                        w_last_nxt  = 1'b1;
                        w_state_nxt = StSingle;
                    end
                end
            end
            StSingle: begin
                if (i_abort || w_hs) begin
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = 1'b0;
                    w_state_nxt = StIdle;
                end
            end
            StStream: begin
                if (i_abort || (w_hs && r_out_last)) begin
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = 1'b0;
                    w_state_nxt = StIdle;
                end else if (w_hs) begin
                    w_idx_nxt  = w_cur_inc;
                    w_word_nxt = w_sel_word;
                    w_last_nxt = (w_cur_inc == LAST_IDX);
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_buf       <= '0;
            r_out_word  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_cur_idx   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_buf       <= w_buf_nxt;
            r_out_word  <= w_word_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_last  <= w_last_nxt;
            r_cur_idx   <= w_idx_nxt;
        end
    end

    assign o_out_word  = r_out_word;
    assign o_out_valid = r_out_valid;
    assign o_out_last  = r_out_last;
    assign o_busy      = (r_state != StIdle);

endmodule

// File: tb/tb_keccak_word_sel.sv
// Self-checking bench for keccak_word_sel: directed scenarios then random traffic vs a read-queue model.
module tb_keccak_word_sel;

    localparam int WIDE = 512;
    localparam int WORD = 32;
    localparam int NW   = WIDE / WORD;

    logic            clk;
    logic            rst_n;
    logic            load;
    logic [WIDE-1:0] in_wide;
    logic            rd_req;
    logic            rd_mode;
    logic [3:0]      rd_idx;
    logic            abort;
    logic [WORD-1:0] out_word;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            busy;
`ifdef KECCAK_SEL_BYTESWAP_EN
    logic            swap_en;
`endif

    keccak_word_sel #(
        .WIDE_W (WIDE),
        .WORD_W (WORD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef KECCAK_SEL_BYTESWAP_EN
        .i_swap_en   (swap_en),
`endif
        .i_load      (load),
        .i_in_wide   (in_wide),
        .i_rd_req    (rd_req),
        .i_rd_mode   (rd_mode),
        .i_rd_idx    (rd_idx),
        .i_abort     (abort),
        .o_out_word  (out_word),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_last  (out_last),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned     n_checks;
    int unsigned     n_errors;
    logic [WORD-1:0] mbuf [NW];
    logic [WORD-1:0] exp_q [$];
    logic [WIDE-1:0] pat_a, pat_b, pat_r;

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic chk32(input string tag, input logic [WORD-1:0] obs,
                         input logic [WORD-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        chk1("out_valid", out_valid, exp_q.size() != 0);
        chk1("busy", busy, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk32("out_word", out_word, exp_q[0]);
            chk1("out_last", out_last, exp_q.size() == 1);
        end else begin
            chk1("out_last_idle", out_last, 1'b0);
        end
    endtask

    // Model: an idle selector either captures data or turns a request into a list of pending words.
    task automatic cycle(input logic ld, input logic [WIDE-1:0] wide, input logic rq,
                         input logic md, input logic [3:0] ix, input logic ab, input logic rdy);
        int lo, hi;
        if (exp_q.size() == 0) begin
            if (ld) begin
                for (int k = 0; k < NW; k++) mbuf[k] = wide[k*WORD +: WORD];
            end else if (rq) begin
                lo = int'(ix);
                hi = md ? NW - 1 : lo;
                for (int k = lo; k <= hi; k++) exp_q.push_back(mbuf[k]);
            end
        end else if (ab) begin
            exp_q.delete();
        end else if (rdy) begin
            void'(exp_q.pop_front());
        end
        load      = ld;
        in_wide   = wide;
        rd_req    = rq;
        rd_mode   = md;
        rd_idx    = ix;
        abort     = ab;
        out_ready = rdy;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle_cycle(input logic rdy);
        cycle(1'b0, '0, 1'b0, 1'b0, 4'd0, 1'b0, rdy);
    endtask

    task automatic chk_all_zero(input string tag);
        chk32({tag, "_word"}, out_word, 32'h0);
        chk1({tag, "_valid"}, out_valid, 1'b0);
        chk1({tag, "_last"}, out_last, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
`ifdef KECCAK_SEL_BYTESWAP_EN
        swap_en  = 1'b0;
`endif
        for (int k = 0; k < NW; k++) begin
            pat_a[k*WORD +: WORD] = 32'hA0 + 32'(k);
            pat_b[k*WORD +: WORD] = 32'hB000 + 32'(k);
            mbuf[k] = '0;
        end

        // Reset held with random inputs toggling
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < NW; k++) in_wide[k*WORD +: WORD] = $urandom;
            load      = 1'($urandom_range(0, 1));
            rd_req    = 1'($urandom_range(0, 1));
            rd_mode   = 1'($urandom_range(0, 1));
            rd_idx    = 4'($urandom_range(0, 15));
            abort     = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            chk_all_zero("in_reset");
        end
        rd_req = 1'b0;
        load   = 1'b0;
        rst_n  = 1'b1;
        repeat (5) idle_cycle(1'($urandom_range(0, 1)));
        chk32("idle_word", out_word, 32'h0);

        // Single read with backpressure
        cycle(1'b1, pat_a, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0);
        chk32("single_word", out_word, 32'hA5);
        repeat (3) idle_cycle(1'b0);
        chk32("single_held", out_word, 32'hA5);
        idle_cycle(1'b1);
        chk1("single_done", busy, 1'b0);

        // Full stream at full throughput
        cycle(1'b0, '0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
        repeat (15) idle_cycle(1'b1);
        chk32("stream_last_word", out_word, 32'hAF);
        idle_cycle(1'b1);
        chk1("stream_done", busy, 1'b0);

        // Stream near the top with toggling ready
        cycle(1'b0, '0, 1'b1, 1'b1, 4'd13, 1'b0, 1'b1);
        idle_cycle(1'b1);
        idle_cycle(1'b0);
        idle_cycle(1'b0);
        chk32("bp_held", out_word, 32'hAE);
        idle_cycle(1'b1);
        idle_cycle(1'b1);

        // Abort after two words
        cycle(1'b0, '0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b1);
        idle_cycle(1'b1);
        idle_cycle(1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        chk1("abort_valid", out_valid, 1'b0);

        // Abort in idle must not block a load
        cycle(1'b1, pat_b, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1);
        idle_cycle(1'b1);

        // Asynchronous reset in the middle of a stream
        cycle(1'b0, '0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b1);
        idle_cycle(1'b1);
        load = 1'b0; rd_req = 1'b0; abort = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        exp_q.delete();
        for (int k = 0; k < NW; k++) mbuf[k] = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, '0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
        repeat (16) idle_cycle(1'b1);

        // Load + rd_req together, then load during a busy stream
        cycle(1'b1, pat_a, 1'b1, 1'b1, 4'd4, 1'b0, 1'b1);
        chk1("collide_no_read", out_valid, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1, 4'd10, 1'b0, 1'b1);
        cycle(1'b1, pat_b, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1);
        chk32("busy_load_ignored", out_word, 32'hAB);
        repeat (5) idle_cycle(1'b1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NW; k++) pat_r[k*WORD +: WORD] = $urandom;
            cycle(1'($urandom_range(0, 9) == 0), pat_r, 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keccak_word_sel.md
Name: keccak_word_sel

Overview:
- Parametrised, registered successor to the combinational 512→32 word selector between keccak_ctrl and the custom-instruction datapath.
- Captures one wide Keccak state/digest slice into an internal buffer on `load`.
- Returns words either by random index (single read) or as an auto-incrementing stream under a valid/ready handshake.
- Sits between keccak_ctrl (wide side) and the processor custom-instruction result path (narrow side).

Parameters:
- WIDE_W, 512, width of captured vector in bits.
- WORD_W, 32, width of each output word.
- NWORDS, WIDE_W/WORD_W, derived (localparam); must be a power of two ≥2 (elaboration error otherwise).
- IDX_W, clog2(NWORDS), derived (localparam); index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  capture in_wide into buffer (honoured only in IDLE).
- in_wide  in  WIDE_W  wide data from keccak_ctrl.
- rd_req  in  1  start a read (honoured only in IDLE).
- rd_mode  in  1  0 = single random read, 1 = stream from rd_idx to NWORDS-1.
- rd_idx  in  IDX_W  start/target word index; word k = buf[k*WORD_W +: WORD_W].
- abort  in  1  synchronous flush to IDLE.
- out_word  out  WORD_W  selected word.
- out_valid  out  1  out_word valid.
- out_ready  in  1  consumer accepts out_word.
- out_last  out  1  high with final word of a read.
- busy  out  1  high when not IDLE.

Behaviour:
- Interface (already decided): one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: buf=0, out_word=0, out_valid=0, out_last=0, busy=0, cur_idx=0, state=IDLE. Reset mid-read discards the read; no word is emitted after deassertion.
- States:
  - IDLE: busy=0, out_valid=0.
  - SINGLE: one word pending.
  - STREAM: words pending.
- IDLE priority: load > rd_req.
  - load=1: buf<=in_wide, stay IDLE; rd_req in the same cycle is ignored.
  - rd_req=1 with rd_mode=0: out_word<=word[rd_idx], out_last<=1, out_valid<=1, go SINGLE.
  - rd_req=1 with rd_mode=1: out_word<=word[rd_idx], cur_idx<=rd_idx, out_last<=(rd_idx==NWORDS-1), out_valid<=1, go STREAM.
- Latency: first word is valid the cycle after rd_req (1 clk).
- SINGLE: hold out_word/out_valid stable until out_valid&&out_ready; then out_valid<=0, out_last<=0, go IDLE.
- STREAM, on each handshake:
  - If out_last: out_valid<=0, out_last<=0, go IDLE.
  - Else: cur_idx<=cur_idx+1, out_word<=word[cur_idx+1], out_last<=(cur_idx+1==NWORDS-1), out_valid stays 1.
  - Throughput is 1 word/clk with out_ready held high. No bubble between words.
- Backpressure: while out_ready=0, out_word, out_last and cur_idx are frozen.
- cur_idx never wraps; the stream ends at NWORDS-1.
- load, rd_req, rd_mode and rd_idx are ignored while busy. buf is stable for the whole read.
- abort (any state): out_valid<=0, out_last<=0, go IDLE next edge. abort has priority over a same-cycle handshake. abort in IDLE has no effect and does not block a same-cycle load/rd_req (abort wins only when busy).
- Same-cycle handshake and any new-request input while busy: only the handshake acts.

Optional Feature:
- KECCAK_SEL_BYTESWAP_EN: adds input port swap_en (1 bit, sampled with rd_req, held for the read).
  - When set, every emitted word is byte-reversed: bytes [7:0]↔[WORD_W-1:WORD_W-8], etc.
  - Requires WORD_W%8==0.
- Without the macro: no swap_en port, words emitted as stored.

Decomposition:
- Package keccak_sel_pkg:
  - state enum (IDLE, SINGLE, STREAM).
  - clog2 function.
  - byteswap function (parametrised by WORD_W).
  - default WIDE_W/WORD_W constants.
- Sub-module keccak_word_mux: purely combinational indexed part-select (buf, idx → word), instantiated once. It is used for both the rd_idx and cur_idx+1 paths via a 2:1 index select.

Test Plan:
- Reset/idle: hold rst_n=0 with random inputs → out_word=0, out_valid=0, busy=0. Release, idle 5 clk → outputs unchanged.
- Single read: load in_wide={16 words, word k=32'hA0+k}, rd_req with rd_mode=0, rd_idx=5 → next clk out_word=32'hA5, out_valid=1, out_last=1. out_ready=0 for 3 clk keeps it stable; out_ready=1 → IDLE next clk.
- Full stream: rd_mode=1, rd_idx=0, out_ready=1 → 16 consecutive words 32'hA0..32'hAF on clk 1..16, out_last only with 32'hAF, busy drops after it.
- Backpressure mid-stream: rd_idx=13, out_ready toggles 1,0,0,1,1 → emitted sequence exactly AD,AE,AF, each held while ready=0, then IDLE.
- Abort/reset mid-stream: rd_idx=2, abort after 2 words → out_valid=0 next clk, busy=0. Repeat with rst_n pulse → all outputs 0 asynchronously, buf=0.
- Priority and collision: load and rd_req together in IDLE → buf updated, no read started. load while STREAM busy → buf unchanged, stream words match the old data.
